// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
// Shared types and constants for the round-robin mux-select arbiter.
//   state_t : arbiter FSM state (IDLE waits for a request, GRANT holds the mux)
//   NUM_REQ : number of requesters / mux inputs
//   sel_t   : mux select type, wide enough to index NUM_REQ inputs
package mux_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int NUM_REQ = 4;

   typedef logic [1:0] sel_t;

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4
// Combinational round-robin picker for four requesters.
// Ports:
//   req      [3:0] : request vector, bit i is requester i
//   last_idx [1:0] : most recently served requester (lowest priority now)
//   win      [1:0] : first requester with req set, scanning last_idx+1 .. last_idx+4
//   any            : at least one request is present
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  sel_t               last_idx,
   output sel_t               win,
   output logic               any
);

   // Scan from the farthest offset back to the nearest one, so the nearest
   // requesting index after last_idx is the one left standing. Offset 4 wraps
   // to last_idx itself, which lets a lone requester win again.
   always_comb begin
      win = last_idx;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req[last_idx + 2'(k)]) begin
            win = last_idx + 2'(k);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/rr_mux_sel_arbiter.sv
// rr_mux_sel_arbiter
// Round-robin arbiter driving the select of a downstream 4:1 data mux.
// The winner keeps the mux for up to MAX_BURST accepted beats, then priority
// rotates past it. A one-cycle idle bubble always separates two grants.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   req       : per-requester request, bit i is mux input i
//   out_ready : downstream accepts the current muxed beat
//   sel       : registered mux select (index of granted requester)
//   grant     : registered one-hot grant, zero when idle
//   out_valid : high exactly while a grant is held
//   last_beat : current beat is the final one of this grant (qualified by out_valid)
module rr_mux_sel_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = $clog2(MAX_BURST + 1)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               out_ready,
   output sel_t               sel,
   output logic [NUM_REQ-1:0] grant,
   output logic               out_valid,
   output logic               last_beat
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   sel_t             last_idx;
   sel_t             win;
   logic             any_req;
   logic             xfer;
   logic             owner_req;
   logic             release_now;

   rr_pick4 u_pick (
      .req      (req),
      .last_idx (last_idx),
      .win      (win),
      .any      (any_req)
   );

   assign xfer      = out_valid && out_ready;
   assign owner_req = req[sel];

   // A dropped request releases whether or not a beat moved this cycle; a
   // full burst releases only on the beat that completes it. Both together
   // are still one release.
   assign release_now = !owner_req || (xfer && (cnt == LAST_CNT));

   assign last_beat = (state == GRANT) && ((cnt == LAST_CNT) || !owner_req);

   // Single FSM with registered outputs. sel is deliberately left alone on
   // release so the mux select only moves when a new grant is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         last_idx  <= 2'd3;
         sel       <= 2'd0;
         grant     <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  sel       <= win;
                  grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                  out_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (release_now) begin
                  grant     <= '0;
                  out_valid <= 1'b0;
                  last_idx  <= sel;
                  cnt       <= '0;
                  state     <= IDLE;
               end else if (xfer) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
